// File: rtl/mont_exp_ctrl_if.sv
// mont_exp_ctrl_if: bus between the exponentiation sequencer and one mont_mult instance
// Signals: md_start - one-cycle multiply request; mm_len/mm_a/mm_b/mm_mod - operands
//          md_end - multiply completion pulse; mm_in - product, valid with md_end
// Modports: master (sequencer side), slave (multiplier side)
interface mont_exp_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int LEN_W = 8
);
   logic             md_start;
   logic [LEN_W-1:0] mm_len;
   logic [WIDTH-1:0] mm_a;
   logic [WIDTH-1:0] mm_b;
   logic [WIDTH-1:0] mm_mod;
   logic             md_end;
   logic [WIDTH-1:0] mm_in;
   modport master (output md_start, mm_len, mm_a, mm_b, mm_mod, input md_end, mm_in);
   modport slave (input md_start, mm_len, mm_a, mm_b, mm_mod, output md_end, mm_in);
endinterface

// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: left-to-right square-and-multiply modular exponentiation sequencer for one mont_mult
// Ports: clk, rstn             - clock, asynchronous active-low reset
//        start                 - one-cycle request, accepted only when idle
//        len, base, exponent,
//        exp_len, modulus,
//        r2_mod                - host operands, registered on an accepted start
//        busy, done, err       - status; err (timeout) is valid with done
//        result                - base^exponent mod modulus, held until the next completion
//        mm                    - multiplier bus (master modport)
// Optional feature: define MEXP_TIMEOUT_EN for a TIMEOUT-cycle md_end watchdog
module mont_exp_ctrl #(
   parameter int WIDTH   = 32,
   parameter int LEN_W   = 8,
   parameter int TIMEOUT = 65535
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [WIDTH-1:0] base,
   input  logic [WIDTH-1:0] exponent,
   input  logic [5:0]       exp_len,
   input  logic [WIDTH-1:0] modulus,
   input  logic [WIDTH-1:0] r2_mod,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result,
   mont_exp_ctrl_if.master  mm
);
   typedef enum logic [2:0] {IDLE, CONV_B, CONV_1, SQR, MUL, FINAL, DONE} state_t;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   state_t           state_q, state_d;
   logic             waiting_q, waiting_d;
   logic [5:0]       idx_q, idx_d, el_q, el_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [WIDTH-1:0] base_q, base_d, exp_q, exp_d, mod_q, mod_d, r2_q, r2_d;
   logic [WIDTH-1:0] acc_q, acc_d, bm_q, bm_d, res_q, res_d;
   logic             op, issue, fin, bit_i;
`ifdef MEXP_TIMEOUT_EN
   logic             err_q, err_d, tmo;
   logic [15:0]      wd_q, wd_d;
   assign tmo = op && waiting_q && !mm.md_end && wd_q == 16'(TIMEOUT - 1);
   assign err = err_q;
`else
   logic             unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign err = 1'b0;
`endif
   assign op     = state_q != IDLE && state_q != DONE;
   // issue phase is the single cycle before waiting is set, so md_start is one cycle wide
   assign issue  = op && !waiting_q;
   assign fin    = op && waiting_q && mm.md_end;
   assign bit_i  = |(exp_q & (ONE << idx_q));
   assign busy   = state_q != IDLE;
   assign done   = state_q == DONE;
   assign result = res_q;
   assign mm.md_start = issue;
   assign mm.mm_len   = len_q;
   assign mm.mm_mod   = mod_q;
   assign mm.mm_a = state_q == CONV_B ? base_q :
                    state_q == CONV_1 ? ONE :
                    (state_q == SQR || state_q == MUL || state_q == FINAL) ? acc_q : '0;
   assign mm.mm_b = (state_q == CONV_B || state_q == CONV_1) ? r2_q :
                    state_q == SQR ? acc_q :
                    state_q == MUL ? bm_q :
                    state_q == FINAL ? ONE : '0;
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      el_d    = el_q;
      len_d   = len_q;
      base_d  = base_q;
      exp_d   = exp_q;
      mod_d   = mod_q;
      r2_d    = r2_q;
      acc_d   = acc_q;
      bm_d    = bm_q;
      res_d   = res_q;
`ifdef MEXP_TIMEOUT_EN
      err_d   = err_q;
      wd_d    = issue ? '0 : waiting_q ? wd_q + 16'd1 : wd_q;
`endif
      case (state_q)
         IDLE: if (start) begin
            state_d = CONV_B;
            el_d    = exp_len;
            len_d   = len;
            base_d  = base;
            exp_d   = exponent;
            mod_d   = modulus;
            r2_d    = r2_mod;
`ifdef MEXP_TIMEOUT_EN
            err_d   = 1'b0;
`endif
         end
         CONV_B: if (fin) begin
            bm_d    = mm.mm_in;
            state_d = CONV_1;
         end
         CONV_1: if (fin) begin
            acc_d   = mm.mm_in;
            idx_d   = el_q - 6'd1;
            state_d = el_q == 6'd0 ? FINAL : SQR;
         end
         // idx_q points at the exponent bit being processed; it steps down once that bit is finished
         SQR: if (fin) begin
            acc_d   = mm.mm_in;
            idx_d   = bit_i ? idx_q : idx_q - 6'd1;
            state_d = bit_i ? MUL : idx_q == 6'd0 ? FINAL : SQR;
         end
         MUL: if (fin) begin
            acc_d   = mm.mm_in;
            idx_d   = idx_q - 6'd1;
            state_d = idx_q == 6'd0 ? FINAL : SQR;
         end
         FINAL: if (fin) begin
            res_d   = mm.mm_in;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
      waiting_d = issue ? 1'b1 : fin ? 1'b0 : waiting_q;
`ifdef MEXP_TIMEOUT_EN
      if (tmo) begin
         state_d   = DONE;
         waiting_d = 1'b0;
         err_d     = 1'b1;
         res_d     = '0;
      end
`endif
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         waiting_q <= 1'b0;
         idx_q     <= '0;
         el_q      <= '0;
         len_q     <= '0;
         base_q    <= '0;
         exp_q     <= '0;
         mod_q     <= '0;
         r2_q      <= '0;
         acc_q     <= '0;
         bm_q      <= '0;
         res_q     <= '0;
`ifdef MEXP_TIMEOUT_EN
         err_q     <= 1'b0;
         wd_q      <= '0;
`endif
      end else begin
         state_q   <= state_d;
         waiting_q <= waiting_d;
         idx_q     <= idx_d;
         el_q      <= el_d;
         len_q     <= len_d;
         base_q    <= base_d;
         exp_q     <= exp_d;
         mod_q     <= mod_d;
         r2_q      <= r2_d;
         acc_q     <= acc_d;
         bm_q      <= bm_d;
         res_q     <= res_d;
`ifdef MEXP_TIMEOUT_EN
         err_q     <= err_d;
         wd_q      <= wd_d;
`endif
      end
   end
endmodule

// File: doc/mont_exp_ctrl.md
# mont_exp_ctrl

Modular-exponentiation sequencer that drives a Montgomery multiplier (`mont_mult`) from the initiator side of its `md_start`/`md_end` handshake. It computes base^exponent mod modulus by left-to-right square-and-multiply in the Montgomery domain. It issues one multiplication at a time and captures each result. It sits between the RSA host registers and a single `mont_mult` instance.

## Interface
- `WIDTH`, 32: operand/modulus width
- `LEN_W`, 8: width of Montgomery length field
- `TIMEOUT`, 65535: watchdog limit in cycles (used only with `MEXP_TIMEOUT_EN`)
- `clk` in 1: clock, all state updates on rising edge
- `rstn` in 1: asynchronous active-low reset
- `start` in 1: one-cycle request; host inputs sampled in that cycle
- `len` in LEN_W: Montgomery length k, R = 2^k
- `base` in WIDTH: base, < modulus
- `exponent` in WIDTH: exponent
- `exp_len` in 6: number of exponent bits used (0..32); bits at and above `exp_len` are ignored
- `modulus` in WIDTH: odd modulus N
- `r2_mod` in WIDTH: R^2 mod N, precomputed by host
- `busy` out 1: high from the cycle after accepted `start` through the `done` cycle
- `done` out 1: one-cycle completion pulse
- `err` out 1: timeout flag, valid with `done`
- `result` out WIDTH: base^exponent mod N, held until next accepted `start`
- `md_start` out 1: one-cycle multiply request to `mont_mult`
- `mm_len` out LEN_W, `mm_a` out WIDTH, `mm_b` out WIDTH, `mm_mod` out WIDTH: multiplier operands
- `md_end` in 1: multiplier completion pulse
- `mm_in` in WIDTH: multiplier result, valid in the `md_end` cycle

## Operation
- MM(a,b) = a·b·R⁻¹ mod N. The operation sequence is:
  - CONV_B: bm = MM(base, r2_mod)
  - CONV_1: acc = MM(1, r2_mod)
  - For i = exp_len-1 down to 0:
    - SQR: acc = MM(acc, acc)
    - MUL: acc = MM(acc, bm), only if exponent[i] = 1
  - FINAL: result = MM(acc, 1)
- States are IDLE, CONV_B, CONV_1, SQR, MUL, FINAL, DONE. Each operation state has an issue phase and a wait phase, tracked by a `waiting` flag.
- Inputs are registered on an accepted `start`. Host inputs may change afterwards without effect.
- `start` is accepted only in IDLE. It is ignored while `busy`.
- exp_len = 0: CONV_1 is followed directly by FINAL, giving result = 1 mod N (3 multiplications total).
- Multiplication count = 3 + exp_len + popcount(exponent[exp_len-1:0]).
- Bit index counter is 6 bits. After SQR/MUL at i = 0, the FSM goes to FINAL.
- `md_end` is ignored unless `waiting` = 1.
- `mm_len`/`mm_mod` are driven from the registered `len`/`modulus` for the whole operation.

## Timing
- Reset values: `busy`, `done`, `err`, `md_start` are 0. `result`, `mm_a`, `mm_b`, `mm_mod`, `mm_len` are 0. FSM is in IDLE.
- Accepted `start` at cycle t: `busy`=1 at t+1 and the first `md_start` at t+1.
- `md_start` is high for exactly one cycle. `mm_a`/`mm_b`/`mm_len`/`mm_mod` are valid in that cycle and held stable until `md_end` is sampled.
- `md_end` sampled at cycle u: `mm_in` is captured at u. The next `md_start` is asserted at u+1, so there are zero idle cycles between operations.
- After the final `md_end` at cycle u: `result` is updated, and `done`=1 at u+1. `busy` falls at u+2. The FSM is in IDLE at u+2, and a new `start` is accepted from u+2.
- `md_end` arriving in the same cycle as `md_start` is not sampled, because `waiting` is set at the end of the issue cycle.
- `rstn` low mid-operation: immediate return to reset values. The multiplier is expected to be reset by the same `rstn`.

## Configuration
- `MEXP_TIMEOUT_EN` defined:
  - A 16-bit watchdog counter clears at every `md_start` and increments while `waiting`.
  - If it reaches `TIMEOUT` before `md_end`, the FSM goes to DONE with `err`=1 and `result`=0.
  - `err` clears on the next accepted `start`.
- `MEXP_TIMEOUT_EN` undefined: no counter. The FSM waits on `md_end` indefinitely. `err` is tied to 0.

## Test plan
The bench uses a behavioral `mont_mult` responder with fixed latency L = 10 (`md_end` 10 cycles after `md_start`). Common settings: len=4, N=13, r2_mod=9 (R=16).
- base=2, exponent=5, exp_len=3 -> 8 `md_start` pulses, `done` 89 cycles after `start`, `result`=6, `err`=0.
- base=7, exponent=4, exp_len=3 -> 7 multiplications, `result`=9; `busy` high for exactly 78 cycles.
- exp_len=0, exponent=0xFFFFFFFF, base=5 -> 3 multiplications, `result`=1; exponent bits ignored.
- Second `start` asserted mid-operation with base=3 -> ignored; `result` matches the first request, and only one `done` pulse occurs.
- `rstn` pulled low during SQR -> all outputs return to reset values, no `done` pulse; after release, a fresh `start` with base=2, exponent=5, exp_len=3 gives `result`=6.
- Responder withholds `md_end`, with `MEXP_TIMEOUT_EN` and TIMEOUT=100 -> `done`=1, `err`=1, `result`=0, about 101 cycles after the first `md_start`. Without the macro, `busy` stays 1 and `done` never asserts.
